// File: rtl/h264invtransform_if.sv
// ============================================================================
// Module      : h264invtransform_if
// Description : Coefficient-in / residual-row-out bundle for the H.264
//               inverse 4x4 transform stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface h264invtransform_if;
  logic               ENABLE;
  logic               DCCI;
  logic signed [15:0] WIN;
  logic               VALID;
  logic [1:0]         ROW;
  logic               LAST;
  logic [39:0]        XOUT;

  modport master (
    output ENABLE, DCCI, WIN,
    input  VALID, ROW, LAST, XOUT
  );

  modport slave (
    input  ENABLE, DCCI, WIN,
    output VALID, ROW, LAST, XOUT
  );
endinterface

`default_nettype wire

// File: rtl/h264invtransform.sv
// ============================================================================
// Module      : h264invtransform
// Description : H.264 4x4 inverse integer transform with ping-pong coefficient
//               buffer; rows emitted one per cycle. Define
//               H264_INVTRANSFORM_SAT_EN to saturate outputs to 10 bits.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module h264invtransform (
  input  logic              CLK,
  input  logic              RESET,
  h264invtransform_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HROW = 2'd1,
    S_VCOL = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Raster position of the k-th coefficient in reverse zigzag order.
  function automatic logic [3:0] zz_of(input logic [3:0] k);
    case (k)
      4'd0:    zz_of = 4'd0;
      4'd1:    zz_of = 4'd1;
      4'd2:    zz_of = 4'd4;
      4'd3:    zz_of = 4'd8;
      4'd4:    zz_of = 4'd5;
      4'd5:    zz_of = 4'd2;
      4'd6:    zz_of = 4'd3;
      4'd7:    zz_of = 4'd6;
      4'd8:    zz_of = 4'd9;
      4'd9:    zz_of = 4'd12;
      4'd10:   zz_of = 4'd13;
      4'd11:   zz_of = 4'd10;
      4'd12:   zz_of = 4'd7;
      4'd13:   zz_of = 4'd11;
      4'd14:   zz_of = 4'd14;
      default: zz_of = 4'd15;
    endcase
  endfunction

  logic [3:0]         k_q, k_d;
  logic               load_sel_q, load_sel_d;
  logic               wr_en;
  logic [3:0]         wr_idx;
  logic               swap;
  logic signed [15:0] coef_q [2][16];

  state_t             state_q;
  logic [1:0]         cnt_q;
  logic               pend_q;
  logic               take;
  logic signed [17:0] mid_q [4][4];
  logic signed [20:0] res_q [4][4];

  logic               valid_q;
  logic [1:0]         row_q;
  logic               last_q;
  logic [39:0]        xout_q;
  logic [39:0]        out_row;

  logic               work_sel;
  logic signed [20:0] ka, kb, kc, kd;
  logic signed [20:0] e0, e1, e2, e3;
  logic signed [20:0] k0, k1, k2, k3;

  // ---------------------------------------------------------------- load side
  always_comb begin
    k_d        = k_q;
    load_sel_d = load_sel_q;
    wr_en      = 1'b0;
    swap       = 1'b0;
    wr_idx     = zz_of(k_q);
    if (io.ENABLE) begin
      if (io.DCCI) begin
        k_d = 4'd15;
      end else begin
        wr_en = 1'b1;
        k_d   = k_q - 4'd1;
        if (k_q == 4'd0) begin
          swap       = 1'b1;
          load_sel_d = ~load_sel_q;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      k_q        <= 4'd15;
      load_sel_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      load_sel_q <= load_sel_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) coef_q[load_sel_q][wr_idx] <= io.WIN;
  end

  // ---------------------------------------------------------- shared kernel
  always_comb begin
    work_sel = ~load_sel_q;
    ka = '0;
    kb = '0;
    kc = '0;
    kd = '0;
    case (state_q)
      S_HROW: begin
        ka = 21'(coef_q[work_sel][{cnt_q, 2'd0}]);
        kb = 21'(coef_q[work_sel][{cnt_q, 2'd1}]);
        kc = 21'(coef_q[work_sel][{cnt_q, 2'd2}]);
        kd = 21'(coef_q[work_sel][{cnt_q, 2'd3}]);
      end
      S_VCOL: begin
        ka = 21'(mid_q[0][cnt_q]);
        kb = 21'(mid_q[1][cnt_q]);
        kc = 21'(mid_q[2][cnt_q]);
        kd = 21'(mid_q[3][cnt_q]);
      end
      default: ;
    endcase
    e0 = ka + kc;
    e1 = ka - kc;
    e2 = (kb >>> 1) - kd;
    e3 = kb + (kd >>> 1);
    k0 = e0 + e3;
    k1 = e1 + e2;
    k2 = e1 - e2;
    k3 = e0 - e3;
  end

  // ------------------------------------------------------ output rounding
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic signed [20:0] rnd;
    logic signed [20:0] sh;
    always_comb begin
      rnd = res_q[cnt_q][c] + 21'sd32;
      sh  = rnd >>> 6;
    end
`ifdef H264_INVTRANSFORM_SAT_EN
    always_comb begin
      if (sh > 21'sd511)       out_row[c*10 +: 10] = 10'h1FF;
      else if (sh < -21'sd512) out_row[c*10 +: 10] = 10'h200;
      else                     out_row[c*10 +: 10] = 10'(sh);
    end
`else
    assign out_row[c*10 +: 10] = 10'(sh);
`endif
  end

  // A swap arriving while busy waits in pend_q; it is started from IDLE or
  // directly at the end of the last output row.
  assign take = (swap || pend_q) &&
                ((state_q == S_IDLE) || (state_q == S_OUT && cnt_q == 2'd3));

  // ---------------------------------------------------------------- engine
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= 2'd0;
      last_q  <= 1'b0;
      xout_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      if (take)      pend_q <= 1'b0;
      else if (swap) pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 2'd0;
          if (take) state_q <= S_HROW;
        end
        S_HROW: begin
          mid_q[cnt_q][0] <= 18'(k0);
          mid_q[cnt_q][1] <= 18'(k1);
          mid_q[cnt_q][2] <= 18'(k2);
          mid_q[cnt_q][3] <= 18'(k3);
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_VCOL;
        end
        S_VCOL: begin
          res_q[0][cnt_q] <= k0;
          res_q[1][cnt_q] <= k1;
          res_q[2][cnt_q] <= k2;
          res_q[3][cnt_q] <= k3;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_OUT;
        end
        S_OUT: begin
          valid_q <= 1'b1;
          row_q   <= cnt_q;
          last_q  <= (cnt_q == 2'd3);
          xout_q  <= out_row;
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= take ? S_HROW : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.VALID = valid_q;
  assign io.ROW   = row_q;
  assign io.LAST  = last_q;
  assign io.XOUT  = xout_q;

endmodule

`default_nettype wire

// File: tb/tb_h264invtransform.sv
// ============================================================================
// Module      : tb_h264invtransform
// Description : Directed self-checking bench for h264invtransform.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_h264invtransform;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  h264invtransform_if bus ();

  h264invtransform dut (
    .CLK   (clk),
    .RESET (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int          q_cyc  [$];
  logic [1:0]  q_row  [$];
  logic        q_last [$];
  logic [39:0] q_xout [$];

  always @(negedge clk) begin
    if (bus.VALID === 1'b1) begin
      q_cyc.push_back(cyc);
      q_row.push_back(bus.ROW);
      q_last.push_back(bus.LAST);
      q_xout.push_back(bus.XOUT);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] va, vb, vc, vd;
    va = a; vb = b; vc = c; vd = d;
    return {vd[9:0], vc[9:0], vb[9:0], va[9:0]};
  endfunction

  function automatic void clear_q();
    q_cyc.delete(); q_row.delete(); q_last.delete(); q_xout.delete();
  endfunction

  // Sends one 16-word block (k=15..0); word at k==pos carries val.
  // Called and returns at a negedge; t_last is the edge sampling k=0.
  task automatic send_block(input int pos, input logic signed [15:0] val,
                            input int gap, output int t_last);
    for (int k = 15; k >= 0; k--) begin
      if (gap > 0 && k == 8) begin
        bus.ENABLE = 1'b0;
        repeat (gap) @(negedge clk);
      end
      bus.ENABLE = 1'b1;
      bus.DCCI   = 1'b0;
      bus.WIN    = (k == pos) ? val : 16'sd0;
      if (k == 0) t_last = cyc + 1;
      @(negedge clk);
    end
    bus.ENABLE = 1'b0;
    bus.WIN    = 16'sd0;
  endtask

  // Pops four rows and checks timing, row index, LAST and data.
  task automatic check_block(input string tag, input int t_last, input logic [39:0] exp);
    check_val({tag, "_rows"}, 64'(q_cyc.size() >= 4), 64'd1);
    if (q_cyc.size() < 4) return;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_cyc%0d", tag, i), 64'(q_cyc.pop_front()), 64'(t_last + 9 + i));
      check_val($sformatf("%s_row%0d", tag, i), 64'(q_row.pop_front()), 64'(i));
      check_val($sformatf("%s_last%0d", tag, i), 64'(q_last.pop_front()), 64'(i == 3));
      check_val($sformatf("%s_x%0d", tag, i), 64'(q_xout.pop_front()), 64'(exp));
    end
  endtask

  initial begin
    int t1, t2;
    logic [39:0] ones, twos, exp_ovf;
    ones    = pack4(1, 1, 1, 1);
    twos    = pack4(2, 2, 2, 2);
`ifdef H264_INVTRANSFORM_SAT_EN
    exp_ovf = pack4(511, 511, 511, 511);
`else
    exp_ovf = pack4(-512, -512, -512, -512);
`endif
    cyc = 0; n_checks = 0; n_errors = 0;
    rst = 1'b1;
    bus.ENABLE = 1'b0; bus.DCCI = 1'b0; bus.WIN = 16'sd0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 64'(bus.VALID), 64'd0);
    check_val("rst_row",   64'(bus.ROW),   64'd0);
    check_val("rst_last",  64'(bus.LAST),  64'd0);
    check_val("rst_xout",  64'(bus.XOUT),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // DC-only block
    clear_q();
    send_block(0, 16'sd64, 0, t1);
    repeat (16) @(negedge clk);
    check_block("dc64", t1, ones);
    check_val("dc64_extra", 64'(q_cyc.size()), 64'd0);
    check_val("hold_xout", 64'(bus.XOUT), 64'(ones));

    // Single AC coefficient, with an input gap mid-block
    clear_q();
    send_block(1, 16'sd64, 3, t1);
    repeat (16) @(negedge clk);
    check_block("ac1", t1, pack4(1, 1, 0, -1));

    // Overflow
    clear_q();
    send_block(0, 16'sd32767, 0, t1);
    repeat (16) @(negedge clk);
    check_block("ovf", t1, exp_ovf);

    // Back-to-back blocks
    clear_q();
    send_block(0, 16'sd64, 0, t1);
    send_block(0, 16'sd128, 0, t2);
    repeat (16) @(negedge clk);
    check_block("b2b_a", t1, ones);
    check_block("b2b_b", t2, twos);

    // DC-stream discard abandons a partial block
    clear_q();
    for (int k = 0; k < 5; k++) begin
      bus.ENABLE = 1'b1; bus.DCCI = 1'b0; bus.WIN = 16'sd100;
      @(negedge clk);
    end
    bus.ENABLE = 1'b1; bus.DCCI = 1'b1; bus.WIN = 16'sd555;
    @(negedge clk);
    bus.DCCI = 1'b0;
    send_block(0, 16'sd64, 0, t1);
    repeat (16) @(negedge clk);
    check_block("dcci", t1, ones);
    check_val("dcci_extra", 64'(q_cyc.size()), 64'd0);

    // Reset mid-transform suppresses the pending block
    clear_q();
    send_block(0, 16'sd64, 0, t1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mrst_xout",  64'(bus.XOUT),  64'd0);
    check_val("mrst_valid", 64'(bus.VALID), 64'd0);
    repeat (12) @(negedge clk);
    check_val("mrst_rows", 64'(q_cyc.size()), 64'd0);
    clear_q();
    send_block(0, 16'sd64, 0, t1);
    repeat (16) @(negedge clk);
    check_block("post_rst", t1, ones);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
